// File: rtl/init_reg_pkg.sv
// Shared definitions for the init_reg_bank: the address-width rule and the
// per-channel request priority encoding.
package init_reg_pkg;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_INC,
    REQ_CLR,
    REQ_WR
  } req_e;

  function automatic int addr_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/init_reg_bank_if.sv
// Request/read bus of the init_reg_bank; master drives strobes, slave answers
// with read data, dirty flags and the overflow pulse.
interface init_reg_bank_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  import init_reg_pkg::*;

  localparam int AW = addr_w(CHANNELS);

  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [WIDTH-1:0]    wr_data;
  logic                inc_en;
  logic [AW-1:0]       inc_addr;
  logic                clr_en;
  logic [AW-1:0]       clr_addr;
  logic [AW-1:0]       rd_addr;
  logic [WIDTH-1:0]    rd_data;
  logic [CHANNELS-1:0] dirty;
  logic                ovf;

  modport master (
    output wr_en, wr_addr, wr_data, inc_en, inc_addr, clr_en, clr_addr, rd_addr,
    input  rd_data, dirty, ovf
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, inc_en, inc_addr, clr_en, clr_addr, rd_addr,
    output rd_data, dirty, ovf
  );

endinterface

// File: rtl/init_reg_cell.sv
// One channel of the bank: value register, dirty bit and the
// write/restore/increment update selected by the decoded request.
module init_reg_cell import init_reg_pkg::*; #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] INIT     = '0,
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  req_e             req,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] value,
  output logic             dirty,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX = '1;

  // Declaration initialisers give the INIT power-up state even without a reset.
  logic [WIDTH-1:0] value_q = INIT;
  logic             dirty_q = 1'b0;

  function automatic logic [WIDTH-1:0] next_inc(input logic [WIDTH-1:0] v);
    if (SATURATE && (v == MAX)) return MAX;
    return v + 1'b1;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value_q <= INIT;
      dirty_q <= 1'b0;
    end else begin
      case (req)
        REQ_WR: begin
          value_q <= wr_data;
          dirty_q <= 1'b1;
        end
        REQ_CLR: begin
          value_q <= INIT;
          dirty_q <= 1'b0;
        end
        REQ_INC: begin
          value_q <= next_inc(value_q);
          dirty_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Only an accepted increment reaches here, so priority-dropped ones never flag.
  assign wrap  = (req == REQ_INC) && (value_q == MAX);
  assign value = value_q;
  assign dirty = dirty_q;

endmodule

// File: rtl/init_reg_bank.sv
// Bank of CHANNELS registers sharing a common power-up/restore value, with
// per-channel write/restore/increment and a combined overflow pulse.
module init_reg_bank import init_reg_pkg::*; #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int INIT     = 7,
  parameter bit SATURATE = 1'b0
) (
  input logic            clock,
  input logic            reset,
  init_reg_bank_if.slave bus
);

  localparam int               AW     = addr_w(CHANNELS);
  localparam logic [WIDTH-1:0] INIT_T = WIDTH'(INIT);

  logic [WIDTH-1:0]    values [CHANNELS];
  logic [CHANNELS-1:0] wraps;
  logic [CHANNELS-1:0] dirty;
  logic                ovf_q = 1'b0;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_cell
    req_e req;

    // Out-of-range addresses never match any channel and so are dropped.
    always_comb begin
      req = REQ_NONE;
      if (bus.wr_en && (bus.wr_addr == AW'(i)))
        req = REQ_WR;
      else if (bus.clr_en && (bus.clr_addr == AW'(i)))
        req = REQ_CLR;
      else if (bus.inc_en && (bus.inc_addr == AW'(i)))
        req = REQ_INC;
    end

    init_reg_cell #(
      .WIDTH    (WIDTH),
      .INIT     (INIT_T),
      .SATURATE (SATURATE)
    ) u_cell (
      .clock   (clock),
      .reset   (reset),
      .req     (req),
      .wr_data (bus.wr_data),
      .value   (values[i]),
      .dirty   (dirty[i]),
      .wrap    (wraps[i])
    );
  end

  always_comb begin
    bus.rd_data = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (bus.rd_addr == AW'(i)) bus.rd_data = values[i];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= |wraps;
  end

  assign bus.dirty = dirty;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_init_reg_bank.sv
// Drives three banks (wrap x4, saturate x4, wrap x3) with one shared request
// stream and compares each against a per-bank behavioural model.
module tb_init_reg_bank;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0, inc_en = 1'b0, clr_en = 1'b0;
  logic [1:0] wr_addr = '0, inc_addr = '0, clr_addr = '0, rd_addr = '0;
  logic [7:0] wr_data = '0;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  init_reg_bank_if #(.WIDTH(8), .CHANNELS(4)) ifa ();
  init_reg_bank_if #(.WIDTH(8), .CHANNELS(4)) ifb ();
  init_reg_bank_if #(.WIDTH(8), .CHANNELS(3)) ifc ();

  assign ifa.wr_en = wr_en;   assign ifb.wr_en = wr_en;   assign ifc.wr_en = wr_en;
  assign ifa.wr_addr = wr_addr; assign ifb.wr_addr = wr_addr; assign ifc.wr_addr = wr_addr;
  assign ifa.wr_data = wr_data; assign ifb.wr_data = wr_data; assign ifc.wr_data = wr_data;
  assign ifa.inc_en = inc_en; assign ifb.inc_en = inc_en; assign ifc.inc_en = inc_en;
  assign ifa.inc_addr = inc_addr; assign ifb.inc_addr = inc_addr; assign ifc.inc_addr = inc_addr;
  assign ifa.clr_en = clr_en; assign ifb.clr_en = clr_en; assign ifc.clr_en = clr_en;
  assign ifa.clr_addr = clr_addr; assign ifb.clr_addr = clr_addr; assign ifc.clr_addr = clr_addr;
  assign ifa.rd_addr = rd_addr; assign ifb.rd_addr = rd_addr; assign ifc.rd_addr = rd_addr;

  init_reg_bank #(.WIDTH(8), .CHANNELS(4), .INIT(7), .SATURATE(1'b0)) dut_a (
    .clock(clock), .reset(reset), .bus(ifa));
  init_reg_bank #(.WIDTH(8), .CHANNELS(4), .INIT(7), .SATURATE(1'b1)) dut_b (
    .clock(clock), .reset(reset), .bus(ifb));
  init_reg_bank #(.WIDTH(8), .CHANNELS(3), .INIT(7), .SATURATE(1'b0)) dut_c (
    .clock(clock), .reset(reset), .bus(ifc));

  // Reference model: value/dirty per channel, ovf per bank.
  int          nch [3] = '{4, 4, 3};
  bit          msat[3] = '{1'b0, 1'b1, 1'b0};
  int unsigned mreg[3][4];
  bit          mdirty[3][4];
  bit          movf[3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      movf[k] = 1'b0;
      for (int c = 0; c < 4; c++) begin
        mreg[k][c]   = 7;
        mdirty[k][c] = 1'b0;
      end
    end
  endtask

  task automatic model_edge();
    if (reset) return;
    for (int k = 0; k < 3; k++) begin
      bit hit = 1'b0;
      for (int c = 0; c < nch[k]; c++) begin
        if (wr_en && wr_addr == c) begin
          mreg[k][c] = wr_data;
          mdirty[k][c] = 1'b1;
        end else if (clr_en && clr_addr == c) begin
          mreg[k][c] = 7;
          mdirty[k][c] = 1'b0;
        end else if (inc_en && inc_addr == c) begin
          if (mreg[k][c] == 255) begin
            hit = 1'b1;
            mreg[k][c] = msat[k] ? 255 : 0;
          end else begin
            mreg[k][c] = mreg[k][c] + 1;
          end
          mdirty[k][c] = 1'b1;
        end
      end
      movf[k] = hit;
    end
  endtask

  function automatic logic [31:0] obs_rd(input int k);
    case (k)
      0: return {24'b0, ifa.rd_data};
      1: return {24'b0, ifb.rd_data};
      default: return {24'b0, ifc.rd_data};
    endcase
  endfunction

  function automatic logic [31:0] obs_dirty(input int k);
    case (k)
      0: return {28'b0, ifa.dirty};
      1: return {28'b0, ifb.dirty};
      default: return {29'b0, ifc.dirty};
    endcase
  endfunction

  function automatic logic [31:0] obs_ovf(input int k);
    case (k)
      0: return {31'b0, ifa.ovf};
      1: return {31'b0, ifb.ovf};
      default: return {31'b0, ifc.ovf};
    endcase
  endfunction

  task automatic cmp(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic check(input string tag);
    logic [31:0] exp_dirty;
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1;
      for (int k = 0; k < 3; k++)
        cmp({tag, "_rd"}, k, obs_rd(k), (a < nch[k]) ? mreg[k][a] : 32'd0);
    end
    for (int k = 0; k < 3; k++) begin
      exp_dirty = '0;
      for (int c = 0; c < nch[k]; c++) exp_dirty[c] = mdirty[k][c];
      cmp({tag, "_dirty"}, k, obs_dirty(k), exp_dirty);
      cmp({tag, "_ovf"}, k, obs_ovf(k), {31'b0, movf[k]});
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; inc_en = 1'b0; clr_en = 1'b0;
  endtask

  task automatic cycle(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    check(tag);
  endtask

  initial begin
    // No reset yet: declaration initialisers alone must give INIT.
    model_reset();
    #1;
    check("powerup");

    reset = 1'b1;
    model_reset();
    cycle("reset");
    reset = 1'b0;
    cycle("idle");

    wr_en = 1'b1; wr_addr = 2; wr_data = 8'hA5;
    cycle("wr_ch2");
    wr_addr = 1; wr_data = 8'h07;
    cycle("wr_ch1_init");

    wr_en = 1'b1; wr_addr = 3; wr_data = 8'h10;
    inc_en = 1'b1; inc_addr = 3; clr_en = 1'b1; clr_addr = 3;
    cycle("prio_ch3");
    wr_en = 1'b0; inc_addr = 0; clr_addr = 1;
    cycle("inc0_clr1");

    idle(); wr_en = 1'b1; wr_addr = 0; wr_data = 8'hFF;
    cycle("wr_ff");
    idle(); inc_en = 1'b1; inc_addr = 0;
    cycle("wrap");
    idle();
    cycle("ovf_drop");
    inc_en = 1'b1;
    for (int n = 0; n < 3; n++) cycle("inc_run");
    idle(); wr_en = 1'b1; wr_addr = 1; wr_data = 8'hFF;
    inc_en = 1'b1; inc_addr = 1;
    cycle("inc_dropped");

    idle(); wr_en = 1'b1; wr_addr = 0; wr_data = 8'h33;
    clr_en = 1'b1; clr_addr = 1;
    cycle("setup33");
    idle(); clr_en = 1'b1; clr_addr = 2;
    cycle("clr2");
    clr_addr = 3;
    cycle("clr3");
    idle(); inc_en = 1'b1; inc_addr = 0;
    reset = 1'b1;
    model_reset();
    check("async_reset");
    cycle("inc_in_reset");
    reset = 1'b0;
    cycle("after_reset");

    idle(); wr_en = 1'b1; wr_addr = 3; wr_data = 8'h5A;
    cycle("wr_addr3");
    idle(); inc_en = 1'b1; inc_addr = 3;
    cycle("inc_addr3");
    idle(); clr_en = 1'b1; clr_addr = 3;
    cycle("clr_addr3");

    for (int n = 0; n < 300; n++) begin
      wr_en = ($urandom_range(0, 3) == 0);
      wr_addr = 2'($urandom);
      case ($urandom_range(0, 2))
        0: wr_data = 8'hFF;
        1: wr_data = 8'hFE;
        default: wr_data = 8'($urandom);
      endcase
      inc_en = ($urandom_range(0, 1) == 1);
      inc_addr = 2'($urandom);
      clr_en = ($urandom_range(0, 4) == 0);
      clr_addr = 2'($urandom);
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/init_reg_bank.md
# init_reg_bank

Parametrised bank of CHANNELS registers, each WIDTH bits wide. Every register powers up at, and resets to, the common value INIT. Channels can be written, incremented (wrapping or saturating) or restored to INIT independently. The bank serves as the shared configuration/counter store for Metron-generated modules that need constructor-initialised state on more than one register.

## Interface
- WIDTH, 8, bits per channel (1..32)
- CHANNELS, 4, number of registers (1..64)
- INIT, 7, power-up/reset/restore value; truncated to WIDTH bits
- SATURATE, 0, increment mode: 0 = wrap at 2^WIDTH-1 -> 0; 1 = hold at 2^WIDTH-1
- clock  in  1  rising-edge clock for all state
- reset  in  1  asynchronous, active-high; forces all state to reset values immediately
- wr_en  in  1  write strobe
- wr_addr  in  AW  write channel; AW = max(1, $clog2(CHANNELS))
- wr_data  in  WIDTH  write value
- inc_en  in  1  increment strobe
- inc_addr  in  AW  channel to increment by 1
- clr_en  in  1  restore strobe
- clr_addr  in  AW  channel to restore to INIT
- rd_addr  in  AW  read channel
- rd_data  out  WIDTH  combinational read of reg[rd_addr]; 0 if rd_addr >= CHANNELS
- dirty  out  CHANNELS  registered; bit i set once channel i is modified since last restore/reset
- ovf  out  1  registered one-cycle pulse: previous cycle's increment hit 2^WIDTH-1

## Operation
- Power-up: every reg = INIT, dirty = 0, ovf = 0, both via reset and via simulation initialisation, so an unreset bench also reads INIT.
- Per rising clock edge, each channel takes the highest-priority request addressed to it: write > restore > increment.
- Write: reg = wr_data; dirty[i] = 1, even if wr_data == INIT.
- Restore: reg = INIT; dirty[i] = 0.
- Increment: reg = reg + 1 mod 2^WIDTH (SATURATE=0), or min(reg+1, 2^WIDTH-1) (SATURATE=1); dirty[i] = 1.
- ovf = 1 on the edge after an accepted increment whose pre-value was 2^WIDTH-1, in both modes. An increment dropped by priority never raises ovf.
- Requests to different channels in the same cycle all take effect.
- Address >= CHANNELS: the request is ignored with no state change, and rd_data reads 0.
- No request addressed to a channel: the channel holds.

## Timing
- Write/inc/restore latency 1: the effect is visible on rd_data in the cycle after the strobe edge.
- rd_data has zero latency from rd_addr; no read-after-write bypass.
- dirty updates on the same edge as the register. ovf is asserted for exactly one cycle, on the edge following the wrapping increment.
- Reset asserted mid-operation: all regs = INIT, dirty = 0 and ovf = 0 asynchronously. Strobes are ignored while reset is high. Normal operation resumes on the first edge after deassertion.
- Back-to-back increments on one channel advance by 1 per cycle. Consecutive wrapping increments in wrap mode produce one ovf pulse per wrap.

## Structure
- Package init_reg_pkg holds:
  - the AW computation function
  - request-priority enum: REQ_NONE, REQ_INC, REQ_CLR, REQ_WR
- Sub-module init_reg_cell holds one channel: register, dirty bit, priority mux and increment/saturate logic, parametrised by WIDTH, INIT and SATURATE.
- The top level contains:
  - a generate loop of CHANNELS cells
  - address decode
  - read mux
  - an OR-reduce of per-cell overflow flags into the ovf register

## Test plan
- Reset then idle, WIDTH=8, CHANNELS=4, INIT=7: rd_addr 0..3 read 7, dirty = 4'b0000, ovf = 0. Repeat with no reset applied: same values.
- Write 0xA5 to ch2, then read ch2: 0xA5 one cycle later, dirty = 4'b0100. Write 7 to ch1: dirty = 4'b0110.
- Same cycle: wr ch3 = 0x10, inc ch3, clr ch3: ch3 = 0x10 and inc dropped. Same cycle: inc ch0, clr ch1: ch0 = 8, ch1 = 7, dirty[1] = 0.
- Wrap vs saturate: with SATURATE=0, write 0xFF to ch0 then inc gives 0x00 and a single ovf pulse. With SATURATE=1, the same sequence gives 0xFF, ovf pulses, and further incs stay 0xFF with ovf each time.
- Reset mid-operation: ch0 = 0x33, dirty = 4'b0001. Raise reset between edges: rd_data = 7 and dirty = 0 before the next edge. An inc held during reset has no effect.
- CHANNELS=3: wr/inc/clr to addr 3 cause no state change; rd_addr = 3 gives rd_data = 0.
